booth_datapath_radix2: RTL and testbench
========================================

Name: booth_datapath_radix2

Overview:
- Datapath companion to the radix-2 Booth multiplier controller; sits directly downstream of it.
- Consumes the controller's Load_words/Shift/Add/Sub/Ready strobes and returns the multiplier LSB (m0) that the controller uses to form its Booth recoding pair.
- Holds the operand and accumulator registers, performs signed add/subtract/shift steps, and publishes a registered 2*L_word signed product with a one-cycle valid pulse.
- Also flags illegal control combinations.

Parameters:
- L_word, 4, operand width in bits; both operands are two's-complement signed. Product width is 2*L_word.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous active-high reset.
- i_load_words  input  1  load operands and clear the accumulator (controller Load_words).
- i_shift  input  1  shift step (controller Shift).
- i_add  input  1  accumulate multiplicand (controller Add).
- i_sub  input  1  subtract multiplicand (controller Sub).
- i_ready  input  1  controller done indication, high for exactly one cycle (controller Ready).
- i_multiplicand  input  L_word  signed multiplicand, sampled only on load.
- i_multiplier  input  L_word  signed multiplier, sampled only on load.
- o_m0  output  1  multiplier register bit 0, combinational from the register (feeds controller i_m0).
- o_product  output  2*L_word  registered signed product of the last completed job.
- o_valid  output  1  one-cycle pulse: o_product updated.
- o_busy  output  1  job in progress.
- o_err  output  1  sticky illegal-control flag.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-high (rst).
- Reset values: all internal registers, o_product, o_valid, o_busy and o_err are 0. Consequently o_m0 = 0.
- Internal registers:
  - mcand_r: 2*L_word bits.
  - mplier_r: L_word bits.
  - acc_r: 2*L_word bits.
- Load (i_load_words=1):
  - mcand_r <= sign-extended i_multiplicand.
  - mplier_r <= i_multiplier.
  - acc_r <= 0.
  - o_busy <= 1.
  - o_err <= 0.
  - The new o_m0 is visible the cycle after load, when the controller evaluates its first recoding pair.
- Add: acc_r <= acc_r + mcand_r, modulo 2^(2*L_word).
- Sub: acc_r <= acc_r - mcand_r, modulo 2^(2*L_word).
- Shift:
  - mcand_r <= mcand_r << 1 (zero fill).
  - mplier_r <= mplier_r >> 1 (logical, zero fill).
  - acc_r unchanged.
- Strobes are mutually exclusive in legal use. If two or more of load/shift/add/sub are high in the same cycle:
  - o_err <= 1 (sticky until next load or reset).
  - Only load is honoured if it is among them; otherwise no register changes.
- No strobe: all data registers hold.
- Completion: on a rising edge where i_ready=1 and o_busy=1:
  - o_product <= acc_r.
  - o_valid <= 1 for exactly one cycle.
  - o_busy <= 0.
- i_ready with o_busy=0 is ignored (no duplicate valid).
- Back-to-back jobs: i_ready and i_load_words high in the same cycle both take effect:
  - The product of the finished job is captured, with o_valid pulsing.
  - The new operands load, and o_busy stays 1.
- Load while busy (restart):
  - The aborted job produces no o_valid.
  - o_product retains the previous result.
- Latency: o_valid is asserted on the clock edge that samples i_ready, i.e. 1 cycle after the controller enters its done state. Total job length is L_word decision steps plus the shifts chosen by the controller.
- Arithmetic: Booth radix-2 with the shifted-multiplicand scheme. No shift is required after the final step. The result is exact for the full signed range, including (-2^(L_word-1))^2.
- Reset mid-operation: immediate clear of everything, including o_valid; the job is lost.

Test Plan:
- Directed control sequence with M=3, Q=5: load, sub, shift, add, shift, sub, shift, add, ready -> o_product=0x0F, one o_valid pulse, o_busy 1->0.
- Paired with the controller, run three jobs: M=-8,Q=-8 -> o_product=0x40; M=7,Q=-8 -> o_product=0xC8; M=-1,Q=7 -> o_product=0xF9. Each job gives one o_valid pulse.
- Exhaustive sweep of all 256 operand pairs with L_word=4, paired with the controller -> o_product equals the signed product for every pair; o_err never set.
- Add and sub high in the same cycle mid-job -> o_err=1 next cycle, acc_r unchanged; o_err stays high until the next load clears it.
- Assert rst asynchronously between clock edges mid-job -> all outputs 0 immediately; a subsequent job with M=2, Q=3 gives 0x06.
- i_ready and i_load_words in the same cycle -> previous product captured with o_valid pulse, o_busy stays 1, new job completes correctly.

Source files
------------

// File: rtl/booth_datapath_radix2_if.sv
// Strobe/operand/result bundle between the radix-2 Booth controller and its datapath.
interface booth_datapath_radix2_if #(
  parameter int L_word = 4
);
  logic                  i_load_words;
  logic                  i_shift;
  logic                  i_add;
  logic                  i_sub;
  logic                  i_ready;
  logic [L_word-1:0]     i_multiplicand;
  logic [L_word-1:0]     i_multiplier;
  logic                  o_m0;
  logic [2*L_word-1:0]   o_product;
  logic                  o_valid;
  logic                  o_busy;
  logic                  o_err;

  modport master (
    output i_load_words, i_shift, i_add, i_sub, i_ready, i_multiplicand, i_multiplier,
    input  o_m0, o_product, o_valid, o_busy, o_err
  );

  modport slave (
    input  i_load_words, i_shift, i_add, i_sub, i_ready, i_multiplicand, i_multiplier,
    output o_m0, o_product, o_valid, o_busy, o_err
  );
endinterface

// File: rtl/booth_datapath_radix2.sv
// Radix-2 Booth datapath: operand/accumulator registers driven by controller strobes,
// registered signed product with a one-cycle valid pulse and a sticky illegal-control flag.
module booth_datapath_radix2 #(
  parameter int L_word = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  booth_datapath_radix2_if.slave   bus
);
  localparam int PW = 2 * L_word;

  logic [PW-1:0]     mcand_r;
  logic [PW-1:0]     acc_r;
  logic [PW-1:0]     product_r;
  logic [L_word-1:0] mplier_r;
  logic              busy_r;
  logic              valid_r;
  logic              err_r;

  logic [PW-1:0]     mcand_nxt_s;
  logic [PW-1:0]     acc_nxt_s;
  logic [L_word-1:0] mplier_nxt_s;
  logic              illegal_s;
  logic              done_s;

  function automatic logic [2:0] strobe_count(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Next-state of the data registers; a load wins even inside an illegal combination.
  always_comb begin
    illegal_s    = (strobe_count({bus.i_load_words, bus.i_shift, bus.i_add, bus.i_sub}) > 3'd1);
    done_s       = bus.i_ready & busy_r;
    mcand_nxt_s  = mcand_r;
    mplier_nxt_s = mplier_r;
    acc_nxt_s    = acc_r;
    if (bus.i_load_words) begin
      mcand_nxt_s  = {{L_word{bus.i_multiplicand[L_word-1]}}, bus.i_multiplicand};
      mplier_nxt_s = bus.i_multiplier;
      acc_nxt_s    = {PW{1'b0}};
    end else if (illegal_s) begin
      mcand_nxt_s  = mcand_r;
      mplier_nxt_s = mplier_r;
      acc_nxt_s    = acc_r;
    end else begin
      case ({bus.i_shift, bus.i_add, bus.i_sub})
        3'b100: begin
          mcand_nxt_s  = mcand_r << 1;
          mplier_nxt_s = mplier_r >> 1;
        end
        3'b010:  acc_nxt_s = acc_r + mcand_r;
        3'b001:  acc_nxt_s = acc_r - mcand_r;
        default: acc_nxt_s = acc_r;
      endcase
    end
  end

  // Operand and accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_r  <= {PW{1'b0}};
      mplier_r <= {L_word{1'b0}};
      acc_r    <= {PW{1'b0}};
    end else begin
      mcand_r  <= mcand_nxt_s;
      mplier_r <= mplier_nxt_s;
      acc_r    <= acc_nxt_s;
    end
  end

  // Job status, result capture and error flag; done samples acc_r before any same-edge load clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product_r <= {PW{1'b0}};
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      valid_r <= done_s;
      if (done_s) begin
        product_r <= acc_r;
      end else begin
        product_r <= product_r;
      end
      if (bus.i_load_words) begin
        busy_r <= 1'b1;
      end else if (done_s) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end
      if (illegal_s) begin
        err_r <= 1'b1;
      end else if (bus.i_load_words) begin
        err_r <= 1'b0;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign bus.o_m0      = mplier_r[0];
  assign bus.o_product = product_r;
  assign bus.o_valid   = valid_r;
  assign bus.o_busy    = busy_r;
  assign bus.o_err     = err_r;
endmodule

// File: tb/tb_booth_datapath_radix2.sv
// Directed bench for booth_datapath_radix2: integer-arithmetic reference model checked every
// cycle, plus literal expectations for the listed jobs, error handling, restart and reset.
module tb_booth_datapath_radix2;
  localparam int L = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  booth_datapath_radix2_if #(.L_word(L)) bus ();
  booth_datapath_radix2 #(.L_word(L)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: plain signed integers, masked to 8 bits on comparison.
  int          m_mc   = 0;
  int          m_acc  = 0;
  int          m_prod = 0;
  int unsigned m_q    = 0;
  bit          m_busy = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_err  = 1'b0;

  function automatic int nstrobes();
    return int'(bus.i_load_words) + int'(bus.i_shift) + int'(bus.i_add) + int'(bus.i_sub);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mc <= 0; m_acc <= 0; m_prod <= 0; m_q <= 0;
      m_busy <= 1'b0; m_valid <= 1'b0; m_err <= 1'b0;
    end else begin
      if (bus.i_load_words) begin
        m_mc  <= int'($signed(bus.i_multiplicand));
        m_q   <= int'(bus.i_multiplier);
        m_acc <= 0;
      end else if (nstrobes() == 1) begin
        if (bus.i_shift) begin
          m_mc <= m_mc * 2;
          m_q  <= m_q / 2;
        end else if (bus.i_add) m_acc <= m_acc + m_mc;
        else if (bus.i_sub) m_acc <= m_acc - m_mc;
      end
      m_valid <= bus.i_ready && m_busy;
      if (bus.i_ready && m_busy) m_prod <= m_acc;
      if (bus.i_load_words) m_busy <= 1'b1;
      else if (bus.i_ready && m_busy) m_busy <= 1'b0;
      if (nstrobes() >= 2) m_err <= 1'b1;
      else if (bus.i_load_words) m_err <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_m0",      32'(bus.o_m0),      32'(m_q & 1));
      chk("cyc_product", 32'(bus.o_product), 32'(m_prod & 255));
      chk("cyc_valid",   32'(bus.o_valid),   32'(m_valid));
      chk("cyc_busy",    32'(bus.o_busy),    32'(m_busy));
      chk("cyc_err",     32'(bus.o_err),     32'(m_err));
    end
  end

  task automatic drive(input bit ld, input bit sh, input bit ad, input bit sb, input bit rd,
                       input int mc, input int mq);
    bus.i_load_words   = ld;
    bus.i_shift        = sh;
    bus.i_add          = ad;
    bus.i_sub          = sb;
    bus.i_ready        = rd;
    bus.i_multiplicand = 4'(mc);
    bus.i_multiplier   = 4'(mq);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  // Booth recoding from the bench's own copy of the multiplier bits.
  task automatic booth_steps(input int q);
    bit prev;
    bit cur;
    prev = 1'b0;
    for (int i = 0; i < L; i++) begin
      cur = q[i];
      chk("step_m0", 32'(bus.o_m0), 32'(cur));
      if (cur && !prev) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      else if (!cur && prev) drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      if (i < L - 1) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
      prev = cur;
    end
  endtask

  task automatic job(input int mc, input int mq);
    int exp;
    exp = (mc * mq) & 255;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mc, mq);
    booth_steps(mq);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    chk("job_valid",   32'(bus.o_valid),   32'd1);
    chk("job_product", 32'(bus.o_product), 32'(exp));
    chk("job_busy",    32'(bus.o_busy),    32'd0);
    chk("job_err",     32'(bus.o_err),     32'd0);
    idle();
    chk("job_valid_drop", 32'(bus.o_valid), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_load_words = 1'b0; bus.i_shift = 1'b0; bus.i_add = 1'b0; bus.i_sub = 1'b0;
    bus.i_ready = 1'b0; bus.i_multiplicand = 4'd0; bus.i_multiplier = 4'd0;
    #1 rst = 1'b1;
    #10;
    chk("rst_product", 32'(bus.o_product), 32'd0);
    chk("rst_valid",   32'(bus.o_valid),   32'd0);
    chk("rst_busy",    32'(bus.o_busy),    32'd0);
    chk("rst_err",     32'(bus.o_err),     32'd0);
    chk("rst_m0",      32'(bus.o_m0),      32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;
    @(posedge clk); #1;

    // M=3, Q=5 with an explicit strobe list
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 5);
    chk("dir_busy", 32'(bus.o_busy), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    chk("dir_product", 32'(bus.o_product), 32'h0F);
    chk("dir_valid",   32'(bus.o_valid),   32'd1);
    chk("dir_busy_end", 32'(bus.o_busy),   32'd0);
    idle();
    chk("dir_valid_once", 32'(bus.o_valid), 32'd0);

    // ready while idle must not pulse valid
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    chk("idle_ready_valid",   32'(bus.o_valid),   32'd0);
    chk("idle_ready_product", 32'(bus.o_product), 32'h0F);

    job(-8, -8);
    chk("m8_m8", 32'(bus.o_product), 32'h40);
    job(7, -8);
    chk("p7_m8", 32'(bus.o_product), 32'hC8);
    job(-1, 7);
    chk("m1_p7", 32'(bus.o_product), 32'hF9);

    // add+sub together: flag set, accumulator untouched, cleared by next load
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 5);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    chk("ill_err", 32'(bus.o_err), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    chk("ill_product", 32'(bus.o_product), 32'h0F);
    chk("ill_err_sticky", 32'(bus.o_err), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 3);
    chk("ill_err_clear", 32'(bus.o_err), 32'd0);
    booth_steps(3);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    chk("ill_next_product", 32'(bus.o_product), 32'h06);
    idle();

    // restart while busy: aborted job yields nothing
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5, -3);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -5, 6);
    chk("restart_valid",   32'(bus.o_valid),   32'd0);
    chk("restart_product", 32'(bus.o_product), 32'h06);
    booth_steps(6);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    chk("restart_result", 32'(bus.o_product), 32'hE2);
    idle();

    // back-to-back: ready and load on the same edge
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7, -8);
    booth_steps(-8);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, 7);
    chk("b2b_valid",   32'(bus.o_valid),   32'd1);
    chk("b2b_product", 32'(bus.o_product), 32'hC8);
    chk("b2b_busy",    32'(bus.o_busy),    32'd1);
    booth_steps(7);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    chk("b2b_second", 32'(bus.o_product), 32'hF9);
    chk("b2b_valid2", 32'(bus.o_valid),   32'd1);
    idle();

    // asynchronous reset between edges mid-job
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5, -3);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_product", 32'(bus.o_product), 32'd0);
    chk("arst_busy",    32'(bus.o_busy),    32'd0);
    chk("arst_valid",   32'(bus.o_valid),   32'd0);
    chk("arst_err",     32'(bus.o_err),     32'd0);
    chk("arst_m0",      32'(bus.o_m0),      32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    job(2, 3);
    chk("arst_job", 32'(bus.o_product), 32'h06);

    // every operand pair
    for (int a = -8; a < 8; a++) begin
      for (int b = -8; b < 8; b++) begin
        job(a, b);
      end
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
